quadrilatero_csr_unit: RTL and testbench

- Parametrised matrix-extension CSR unit for the quadrilatero matrix coprocessor.
- Holds the writable state xmrstart, xmcsr and xmsize, and serves the read-only registers xmlenb, xrlenb and xmisa.
- Takes CSR read/write/set/clear requests over a valid/ready channel and returns old values over a registered response channel.
- Stalls state-modifying accesses while the matrix datapath is busy; absorbs sticky exception flags and restart-row updates from the datapath.

---
 rtl/quadrilatero_csr_unit.sv | 200 ++++++++++++++++++++
 tb/tb_quadrilatero_csr_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_csr_unit.sv
// quadrilatero_csr_unit
//   Matrix-extension CSR unit for the quadrilatero coprocessor. It holds the
//   writable CSRs xmrstart, xmcsr and xmsize, and serves the read-only
//   registers xmlenb, xrlenb and xmisa. Requests arrive on a valid/ready
//   channel. The unit returns the CSR value from before the access on a
//   registered response channel.
//
//   State | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | ready for a request; reads, illegal accesses and accesses made
//         | while the datapath is not busy execute in the accept cycle
//   WAIT_IDLE | a modifying access is held until busy_i drops
//   RESP  | response is valid; the payload is held until resp_ready_i
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_addr_i, req_op_i         CSR address, op (00 rd, 01 wr, 10 set, 11 clr)
//   req_wdata_i                  write/set/clear operand
//   resp_valid_o / resp_ready_i  response handshake
//   resp_rdata_o, resp_illegal_o old CSR value, illegal-access flag
//   busy_i                       matrix datapath has instructions in flight
//   fflags_valid_i, fflags_i     sticky exception flags from the datapath
//   rstart_valid_i, rstart_i     restart-row update from the datapath
//   xmrstart_o, frm_o, size_*_o  current register contents
module quadrilatero_csr_unit #(
  parameter int          RLEN       = 4096,
  parameter logic [31:0] MISA_VALUE = 32'h0000_0010,
  localparam int         N_ROWS     = RLEN / 32,
  localparam int         RW         = $clog2(N_ROWS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [11:0]   req_addr_i,
  input  logic [1:0]    req_op_i,
  input  logic [31:0]   req_wdata_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_illegal_o,
  input  logic          busy_i,
  input  logic          fflags_valid_i,
  input  logic [4:0]    fflags_i,
  input  logic          rstart_valid_i,
  input  logic [RW-1:0] rstart_i,
  output logic [RW-1:0] xmrstart_o,
  output logic [2:0]    frm_o,
  output logic [7:0]    size_m_o,
  output logic [7:0]    size_n_o,
  output logic [15:0]   size_k_o
);

  localparam logic [11:0] ADDR_XMRSTART = 12'h802;
  localparam logic [11:0] ADDR_XMCSR    = 12'h803;
  localparam logic [11:0] ADDR_XMSIZE   = 12'h804;
  localparam logic [11:0] ADDR_XMLENB   = 12'hCC0;
  localparam logic [11:0] ADDR_XRLENB   = 12'hCC1;
  localparam logic [11:0] ADDR_XMISA    = 12'hCC2;

  localparam logic [31:0] XMLENB_VAL = 32'(N_ROWS * RLEN / 8);
  localparam logic [31:0] XRLENB_VAL = 32'(RLEN / 8);
  localparam logic [7:0]  MN_MAX     = 8'(N_ROWS);
  localparam logic [15:0] K_MAX      = 16'(RLEN / 8);

  typedef enum logic [1:0] {IDLE, WAIT_IDLE, RESP} state_t;

  state_t        state_q, state_d;
  logic [11:0]   addr_q;
  logic [1:0]    op_q;
  logic [31:0]   wdata_q;
  logic [RW-1:0] xmrstart_q;
  logic [7:0]    xmcsr_q;
  logic [31:0]   xmsize_q;
  logic [31:0]   resp_rdata_q;
  logic          resp_illegal_q;

  logic [11:0] addr;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic        known, read_only, modifying, illegal;
  logic [31:0] old_val, new_val, size_legal;
  logic        exec, commit;
  logic [7:0]  csr_base;

  // In WAIT_IDLE the held copy drives execution, because the requester has
  // already moved on from the accepted request.
  always_comb begin
    addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
    op    = (state_q == IDLE) ? req_op_i    : op_q;
    wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;

    known     = 1'b1;
    read_only = 1'b0;
    old_val   = '0;
    unique case (addr)
      ADDR_XMRSTART: old_val = {{(32-RW){1'b0}}, xmrstart_q};
      ADDR_XMCSR:    old_val = {24'h0, xmcsr_q};
      ADDR_XMSIZE:   old_val = xmsize_q;
      ADDR_XMLENB:   begin old_val = XMLENB_VAL; read_only = 1'b1; end
      ADDR_XRLENB:   begin old_val = XRLENB_VAL; read_only = 1'b1; end
      ADDR_XMISA:    begin old_val = MISA_VALUE; read_only = 1'b1; end
      default:       known = 1'b0;
    endcase

    // A set or clear with a zero operand changes nothing, so it is a read.
    modifying = (op == 2'b01) || (op[1] && (wdata != 32'h0));
    illegal   = !known || (modifying && read_only);

    unique case (op)
      2'b01:   new_val = wdata;
      2'b10:   new_val = old_val | wdata;
      2'b11:   new_val = old_val & ~wdata;
      default: new_val = old_val;
    endcase

    size_legal[7:0]   = (new_val[7:0]   > MN_MAX) ? MN_MAX : new_val[7:0];
    size_legal[15:8]  = (new_val[15:8]  > MN_MAX) ? MN_MAX : new_val[15:8];
    size_legal[31:16] = (new_val[31:16] > K_MAX)  ? K_MAX  : new_val[31:16];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    exec        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          // Illegal accesses change no state, so they never wait for busy.
          if (modifying && !illegal && busy_i) begin
            state_d = WAIT_IDLE;
          end else begin
            exec    = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT_IDLE: begin
        if (!busy_i) begin
          exec    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = exec && modifying && !illegal;

  // Datapath flags are OR-ed on top of any CSR result so that none are lost.
  assign csr_base = (commit && addr == ADDR_XMCSR) ? new_val[7:0] : xmcsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q         <= '0;
      op_q           <= '0;
      wdata_q        <= '0;
      xmrstart_q     <= '0;
      xmcsr_q        <= '0;
      xmsize_q       <= '0;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        op_q    <= req_op_i;
        wdata_q <= req_wdata_i;
      end
      // A CSR write has priority over a restart-row update in the same cycle.
      if (commit && addr == ADDR_XMRSTART) xmrstart_q <= new_val[RW-1:0];
      else if (rstart_valid_i)             xmrstart_q <= rstart_i;
      xmcsr_q <= csr_base | (fflags_valid_i ? {3'b000, fflags_i} : 8'h00);
      if (commit && addr == ADDR_XMSIZE) xmsize_q <= size_legal;
      if (exec) begin
        resp_rdata_q   <= illegal ? 32'h0 : old_val;
        resp_illegal_q <= illegal;
      end
    end
  end

  assign resp_valid_o   = (state_q == RESP);
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_illegal_o = resp_illegal_q;
  assign xmrstart_o     = xmrstart_q;
  assign frm_o          = xmcsr_q[7:5];
  assign size_m_o       = xmsize_q[7:0];
  assign size_n_o       = xmsize_q[15:8];
  assign size_k_o       = xmsize_q[31:16];

endmodule

// File: tb/tb_quadrilatero_csr_unit.sv
module tb_quadrilatero_csr_unit;
  localparam int RLEN = 4096;
  localparam int NR   = RLEN / 32;
  localparam int RW   = $clog2(NR);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [11:0]   req_addr_i = '0;
  logic [1:0]    req_op_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b1;
  logic [31:0]   resp_rdata_o;
  logic          resp_illegal_o;
  logic          busy_i = 1'b0;
  logic          fflags_valid_i = 1'b0;
  logic [4:0]    fflags_i = '0;
  logic          rstart_valid_i = 1'b0;
  logic [RW-1:0] rstart_i = '0;
  logic [RW-1:0] xmrstart_o;
  logic [2:0]    frm_o;
  logic [7:0]    size_m_o, size_n_o;
  logic [15:0]   size_k_o;

  quadrilatero_csr_unit #(.RLEN(RLEN), .MISA_VALUE(32'h0000_0010)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_illegal_o(resp_illegal_o),
    .busy_i(busy_i), .fflags_valid_i(fflags_valid_i), .fflags_i(fflags_i),
    .rstart_valid_i(rstart_valid_i), .rstart_i(rstart_i),
    .xmrstart_o(xmrstart_o), .frm_o(frm_o),
    .size_m_o(size_m_o), .size_n_o(size_n_o), .size_k_o(size_k_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Reference state, kept as plain integers.
  longint m_rstart, m_csr, m_size;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rstart = 0; m_csr = 0; m_size = 0;
  endtask

  task automatic model_exec(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                            input logic fv, input logic [4:0] ff,
                            input logic rv, input logic [RW-1:0] rs,
                            output logic [31:0] exp_old, output logic exp_ill);
    longint old, nv, m, n, k;
    bit known, ro, mod, csr_hit, rst_hit;
    known = 1; ro = 0; old = 0;
    case (a)
      12'h802: old = m_rstart;
      12'h803: old = m_csr;
      12'h804: old = m_size;
      12'hCC0: begin old = NR * RLEN / 8; ro = 1; end
      12'hCC1: begin old = RLEN / 8; ro = 1; end
      12'hCC2: begin old = 'h10; ro = 1; end
      default: known = 0;
    endcase
    mod = (op == 1) || (op >= 2 && wd != 0);
    exp_ill = !known || (mod && ro);
    exp_old = exp_ill ? 32'h0 : 32'(old);
    csr_hit = 0; rst_hit = 0;
    if (!exp_ill && mod) begin
      if (op == 1)      nv = wd;
      else if (op == 2) nv = old | wd;
      else              nv = old & ~longint'(wd) & 64'hFFFF_FFFF;
      case (a)
        12'h802: begin m_rstart = nv % NR; rst_hit = 1; end
        12'h803: begin m_csr = nv % 256; csr_hit = 1; end
        12'h804: begin
          m = nv % 256;          if (m > NR) m = NR;
          n = (nv / 256) % 256;  if (n > NR) n = NR;
          k = nv / 65536;        if (k > RLEN / 8) k = RLEN / 8;
          m_size = k * 65536 + n * 256 + m;
        end
        default: ;
      endcase
    end
    if (fv) m_csr = m_csr | ff;
    if (rv && !rst_hit) m_rstart = rs;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".xmrstart"}, 32'(xmrstart_o), 32'(m_rstart));
    chk({tag, ".frm"},      32'(frm_o),      32'((m_csr / 32) % 8));
    chk({tag, ".size"},     {size_k_o, size_n_o, size_m_o}, 32'(m_size));
  endtask

  // One access with no busy: accept, check response one cycle later, handshake.
  task automatic access(input string tag, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic fv, input logic [4:0] ff,
                        input logic rv, input logic [RW-1:0] rs);
    logic [31:0] eo; logic ei;
    @(negedge clk_i);
    req_valid_i = 1; req_addr_i = a; req_op_i = op; req_wdata_i = wd;
    fflags_valid_i = fv; fflags_i = ff; rstart_valid_i = rv; rstart_i = rs;
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    model_exec(a, op, wd, fv, ff, rv, rs, eo, ei);
    #1;
    req_valid_i = 0; fflags_valid_i = 0; rstart_valid_i = 0;
    chk({tag, ".rvalid"}, 32'(resp_valid_o), 32'd1);
    chk({tag, ".rdata"}, resp_rdata_o, eo);
    chk({tag, ".illegal"}, 32'(resp_illegal_o), 32'(ei));
    chk_outputs(tag);
    @(posedge clk_i); #1;
    chk({tag, ".done"}, 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] eo, held; logic ei;
    logic [11:0] a; logic [31:0] wd;
    model_reset();
    #12;
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    chk("rst.rvalid", 32'(resp_valid_o), 32'd0);
    chk("rst.rdata", resp_rdata_o, 32'd0);
    chk("rst.illegal", 32'(resp_illegal_o), 32'd0);
    chk_outputs("rst");
    @(negedge clk_i); rst_i = 0;

    access("rd_xrlenb", 12'hCC1, 2'b00, 32'h0, 0, 5'h0, 0, '0);
    access("rd_xmlenb", 12'hCC0, 2'b00, 32'h0, 0, 5'h0, 0, '0);
    access("wr_size", 12'h804, 2'b01, 32'hFFFF_FFFF, 0, 5'h0, 0, '0);
    access("rd_size", 12'h804, 2'b00, 32'h0, 0, 5'h0, 0, '0);
    chk("size_clamped", {size_k_o, size_n_o, size_m_o}, 32'h0200_8080);
    access("wr_misa", 12'hCC2, 2'b01, 32'h1234, 0, 5'h0, 0, '0);
    access("wr_9ff", 12'h9FF, 2'b01, 32'h1234, 0, 5'h0, 0, '0);
    access("set0_misa", 12'hCC2, 2'b10, 32'h0, 0, 5'h0, 0, '0);

    // Modifying access stalled by busy for five cycles.
    @(negedge clk_i);
    busy_i = 1; req_valid_i = 1; req_addr_i = 12'h803; req_op_i = 2'b01; req_wdata_i = 32'hE0;
    chk("busy.ready_accept", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk("busy.ready_low", 32'(req_ready_o), 32'd0);
      chk("busy.no_resp", 32'(resp_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end
    chk("busy.frm_unchanged", 32'(frm_o), 32'((m_csr / 32) % 8));
    @(negedge clk_i); busy_i = 0;
    @(posedge clk_i);
    model_exec(12'h803, 2'b01, 32'hE0, 0, 5'h0, 0, '0, eo, ei);
    #1;
    chk("busy.rvalid", 32'(resp_valid_o), 32'd1);
    chk("busy.rdata", resp_rdata_o, eo);
    chk("busy.frm", 32'(frm_o), 32'd7);
    @(posedge clk_i); #1;

    // Same-cycle datapath flags with a CSR clear of xmcsr.
    access("wr_csr1c", 12'h803, 2'b01, 32'h1C, 0, 5'h0, 0, '0);
    access("clr_csr_ff", 12'h803, 2'b11, 32'h1F, 1, 5'b00011, 0, '0);
    access("rd_csr", 12'h803, 2'b00, 32'h0, 0, 5'h0, 0, '0);
    chk("csr_is_03", 32'(m_csr), 32'h03);
    // CSR write to xmrstart beats a same-cycle restart-row update.
    access("wr_rstart_conf", 12'h802, 2'b01, 32'h1234_5685, 0, 5'h0, 1, 7'h11);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: a = 12'h802; 1: a = 12'h803; 2: a = 12'h804; 3: a = 12'hCC0;
        4: a = 12'hCC1; 5: a = 12'hCC2; 6: a = 12'h805;
        default: a = 12'($urandom);
      endcase
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      access($sformatf("rnd%0d", i), a, 2'($urandom), wd,
             ($urandom_range(0, 3) == 0), 5'($urandom),
             ($urandom_range(0, 3) == 0), RW'($urandom));
    end

    // Stalled response, then reset in the middle of it.
    access("wr_size2", 12'h804, 2'b01, 32'h0040_2010, 0, 5'h0, 0, '0);
    @(negedge clk_i);
    resp_ready_i = 0; req_valid_i = 1; req_addr_i = 12'h804; req_op_i = 2'b00;
    @(posedge clk_i);
    model_exec(12'h804, 2'b00, 32'h0, 0, 5'h0, 0, '0, eo, ei);
    #1; req_valid_i = 0;
    chk("hold.rdata0", resp_rdata_o, eo);
    held = resp_rdata_o;
    @(posedge clk_i); #1;
    chk("hold.rvalid1", 32'(resp_valid_o), 32'd1);
    chk("hold.rdata1", resp_rdata_o, eo);
    chk("hold.illegal1", 32'(resp_illegal_o), 32'd0);
    @(negedge clk_i); rst_i = 1; #1;
    model_reset();
    chk("midrst.rvalid", 32'(resp_valid_o), 32'd0);
    chk("midrst.ready", 32'(req_ready_o), 32'd1);
    chk("midrst.rdata", resp_rdata_o, 32'd0);
    chk_outputs("midrst");
    @(negedge clk_i); rst_i = 0; resp_ready_i = 1;
    access("post_rd_rstart", 12'h802, 2'b00, 32'h0, 0, 5'h0, 0, '0);
    access("post_rd_csr", 12'h803, 2'b00, 32'h0, 0, 5'h0, 0, '0);
    access("post_rd_size", 12'h804, 2'b00, 32'h0, 0, 5'h0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
